// File: rtl/ps2_quadrant_ctrl_pkg.sv
// Shared PS/2 set-2 constants, decoder state type and quadrant key lookup.
package ps2_ctrl_pkg;

  localparam logic [7:0] KEY_BREAK = 8'hF0;
  localparam logic [7:0] KEY_EXT   = 8'hE0;

  localparam logic [7:0] KEY_Q0  = 8'h16;
  localparam logic [7:0] KEY_Q1  = 8'h1E;
  localparam logic [7:0] KEY_Q2  = 8'h26;
  localparam logic [7:0] KEY_Q3  = 8'h25;
  localparam logic [7:0] KEY_Q4  = 8'h2E;
  localparam logic [7:0] KEY_Q5  = 8'h36;
  localparam logic [7:0] KEY_Q6  = 8'h3D;
  localparam logic [7:0] KEY_Q7  = 8'h3E;
  localparam logic [7:0] KEY_Q8  = 8'h46;
  localparam logic [7:0] KEY_Q9  = 8'h15;
  localparam logic [7:0] KEY_Q10 = 8'h1D;
  localparam logic [7:0] KEY_Q11 = 8'h24;
  localparam logic [7:0] KEY_Q12 = 8'h2D;
  localparam logic [7:0] KEY_Q13 = 8'h2C;
  localparam logic [7:0] KEY_Q14 = 8'h35;
  localparam logic [7:0] KEY_Q15 = 8'h3C;

  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} ps2_state_t;

  // Returns {hit, idx}; hit=0 for any code outside the quadrant key set.
  function automatic logic [4:0] code_to_quadrant(input logic [7:0] code);
    logic [4:0] r;
    r = 5'd0;
    case (code)
      KEY_Q0:  r = {1'b1, 4'd0};
      KEY_Q1:  r = {1'b1, 4'd1};
      KEY_Q2:  r = {1'b1, 4'd2};
      KEY_Q3:  r = {1'b1, 4'd3};
      KEY_Q4:  r = {1'b1, 4'd4};
      KEY_Q5:  r = {1'b1, 4'd5};
      KEY_Q6:  r = {1'b1, 4'd6};
      KEY_Q7:  r = {1'b1, 4'd7};
      KEY_Q8:  r = {1'b1, 4'd8};
      KEY_Q9:  r = {1'b1, 4'd9};
      KEY_Q10: r = {1'b1, 4'd10};
      KEY_Q11: r = {1'b1, 4'd11};
      KEY_Q12: r = {1'b1, 4'd12};
      KEY_Q13: r = {1'b1, 4'd13};
      KEY_Q14: r = {1'b1, 4'd14};
      KEY_Q15: r = {1'b1, 4'd15};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_quadrant_ctrl_if.sv
// Byte-receiver input and quadrant-event output bundle of ps2_quadrant_ctrl.
interface ps2_quadrant_ctrl_if;
  // rx_valid is a one-cycle strobe qualifying rx_byte/rx_error (no back-pressure).
  // sel_*: an entry transfers on any clock edge where sel_valid && sel_ready;
  // sel_valid/sel_quadrant hold steady until that transfer.
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_error;
  logic       sel_valid;
  logic       sel_ready;
  logic [3:0] sel_quadrant;

  modport master (output rx_valid, rx_byte, rx_error, sel_ready,
                  input  sel_valid, sel_quadrant);
  modport slave  (input  rx_valid, rx_byte, rx_error, sel_ready,
                  output sel_valid, sel_quadrant);
endinterface

// File: rtl/ps2_quadrant_ctrl_event_fifo.sv
// First-word-fall-through event queue; a push into a full queue is accepted only with a same-cycle pop.
module ps2_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & (~full_o | pop_i);
  assign pop_ok  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_q];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      // When full, the write lands in the slot being popped this same cycle.
      if (push_ok) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_ok) rd_q <= rd_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/ps2_quadrant_ctrl.sv
// PS/2 set-2 quadrant key decoder with event FIFO and LED hold timer.
// Build option: TYPEMATIC_FILTER_EN suppresses pushes for makes of already-held keys.
module ps2_quadrant_ctrl
  import ps2_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 10000000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  ps2_quadrant_ctrl_if.slave              bus,
  output logic [15:0]                     led,
  output logic [15:0]                     held,
  output logic                            overflow,
  input  logic                            overflow_clr,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output ps2_state_t                      dbg_state
);
  localparam int TW = $clog2(HOLD_CYCLES+1);

  ps2_state_t    state_q;
  logic [15:0]   held_q, led_q;
  logic          push_q, overflow_q;
  logic [3:0]    push_idx_q, head;
  logic [TW-1:0] timer_q;
  logic [4:0]    hit_idx;
  logic          make_ok, full, empty, pop;

  assign hit_idx = code_to_quadrant(bus.rx_byte);
`ifdef TYPEMATIC_FILTER_EN
  assign make_ok = ~held_q[hit_idx[3:0]];
`else
  assign make_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      held_q     <= '0;
      push_q     <= 1'b0;
      push_idx_q <= '0;
    end else begin
      push_q <= 1'b0;
      if (bus.rx_valid) begin
        if (bus.rx_error) begin
          state_q <= IDLE;
        end else begin
          case (state_q)
            IDLE: begin
              if (bus.rx_byte == KEY_BREAK)     state_q <= BREAK;
              else if (bus.rx_byte == KEY_EXT)  state_q <= EXT;
              else if (hit_idx[4]) begin
                held_q[hit_idx[3:0]] <= 1'b1;
                push_q               <= make_ok;
                push_idx_q           <= hit_idx[3:0];
              end
            end
            BREAK: begin
              if (hit_idx[4]) held_q[hit_idx[3:0]] <= 1'b0;
              state_q <= IDLE;
            end
            EXT:       state_q <= (bus.rx_byte == KEY_BREAK) ? EXT_BREAK : IDLE;
            EXT_BREAK: state_q <= IDLE;
            default:   state_q <= IDLE;
          endcase
        end
      end
    end
  end

  ps2_event_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(4)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_q),
    .din_i   (push_idx_q),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  assign pop              = bus.sel_valid & bus.sel_ready;
  assign bus.sel_valid    = ~empty;
  assign bus.sel_quadrant = empty ? 4'd0 : head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q      <= '0;
      timer_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop) begin
        led_q   <= 16'(1) << head;
        timer_q <= TW'(HOLD_CYCLES);
      end else if (timer_q != '0) begin
        timer_q <= timer_q - TW'(1);
        if (timer_q == TW'(1)) led_q <= '0;
      end
      // A drop in the same cycle as a clear leaves the flag set.
      if (push_q & full & ~pop) overflow_q <= 1'b1;
      else if (overflow_clr)    overflow_q <= 1'b0;
    end
  end

  assign led       = led_q;
  assign held      = held_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_ps2_quadrant_ctrl.sv
// Directed bench for ps2_quadrant_ctrl (FIFO_DEPTH=4, HOLD_CYCLES=20).
module tb_ps2_quadrant_ctrl;
  import ps2_ctrl_pkg::*;

  localparam int FIFO_DEPTH  = 4;
  localparam int HOLD_CYCLES = 20;

  logic        clk;
  logic        rst_n;
  logic [15:0] led, held;
  logic        overflow, overflow_clr;
  logic [2:0]  fifo_count;
  ps2_state_t  dbg_state;

  ps2_quadrant_ctrl_if bus ();

  ps2_quadrant_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .HOLD_CYCLES(HOLD_CYCLES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .led          (led),
    .held         (held),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .fifo_count   (fifo_count),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input logic err);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    bus.rx_error = err;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_error = 1'b0;
  endtask

  task automatic pop_one(input string tag);
    logic [3:0] e;
    int waited;
    waited = 0;
    while (!bus.sel_valid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_valid"}, 32'(bus.sel_valid), 32'd1);
    e = exp_q.pop_front();
    check({tag, "_quad"}, 32'(bus.sel_quadrant), 32'(e));
    bus.sel_ready = 1'b1;
    @(negedge clk);
    bus.sel_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n         = 1'b0;
    overflow_clr  = 1'b0;
    bus.rx_valid  = 1'b0;
    bus.rx_byte   = 8'h00;
    bus.rx_error  = 1'b0;
    bus.sel_ready = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);

    check("rst_sel_valid", 32'(bus.sel_valid), 32'd0);
    check("rst_sel_quad",  32'(bus.sel_quadrant), 32'd0);
    check("rst_led",       32'(led), 32'd0);
    check("rst_held",      32'(held), 32'd0);
    check("rst_overflow",  32'(overflow), 32'd0);
    check("rst_count",     32'(fifo_count), 32'd0);
    check("rst_state",     32'(dbg_state), 32'(IDLE));

    // 1: make/break of quadrant 0 and LED hold
    send_byte(8'h16, 1'b0);
    exp_q.push_back(4'd0);
    check("t1_held_set", 32'(held), 32'h0001);
    check("t1_valid_lat1", 32'(bus.sel_valid), 32'd0);
    idle(1);
    check("t1_valid_lat2", 32'(bus.sel_valid), 32'd1);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h16, 1'b0);
    check("t1_held_clr", 32'(held), 32'h0000);
    pop_one("t1_pop");
    check("t1_led_on", 32'(led), 32'h0001);
    idle(HOLD_CYCLES - 1);
    check("t1_led_last", 32'(led), 32'h0001);
    idle(1);
    check("t1_led_off", 32'(led), 32'h0000);

    // 2: overflow with sel_ready low
    send_byte(8'h1E, 1'b0); exp_q.push_back(4'd1);
    send_byte(8'h26, 1'b0); exp_q.push_back(4'd2);
    send_byte(8'h25, 1'b0); exp_q.push_back(4'd3);
    send_byte(8'h2E, 1'b0); exp_q.push_back(4'd4);
    send_byte(8'h36, 1'b0);
    idle(2);
    check("t2_count_full", 32'(fifo_count), 32'd4);
    check("t2_overflow",   32'(overflow), 32'd1);
    repeat (4) pop_one("t2_pop");
    check("t2_count_empty", 32'(fifo_count), 32'd0);
    check("t2_ovf_sticky",  32'(overflow), 32'd1);
    @(negedge clk); overflow_clr = 1'b1;
    @(negedge clk); overflow_clr = 1'b0;
    check("t2_ovf_clr", 32'(overflow), 32'd0);

    // 3: extended sequences are ignored
    send_byte(8'hF0, 1'b0); send_byte(8'h1E, 1'b0);
    check("t3_held_base", 32'(held), 32'h003C);
    send_byte(8'hE0, 1'b0);
    check("t3_state_ext", 32'(dbg_state), 32'(EXT));
    send_byte(8'h3C, 1'b0);
    check("t3_state_idle1", 32'(dbg_state), 32'(IDLE));
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    check("t3_state_extbrk", 32'(dbg_state), 32'(EXT_BREAK));
    send_byte(8'h3C, 1'b0);
    check("t3_state_idle2", 32'(dbg_state), 32'(IDLE));
    idle(2);
    check("t3_no_push", 32'(fifo_count), 32'd0);
    check("t3_held_same", 32'(held), 32'h003C);
    send_byte(8'h3C, 1'b0); exp_q.push_back(4'd15);
    check("t3_held15", 32'(held), 32'h803C);
    pop_one("t3_pop");

    // 4: rx_error discards and resets the decoder
    send_byte(8'h15, 1'b1);
    idle(2);
    check("t4_err_nopush", 32'(fifo_count), 32'd0);
    check("t4_err_noheld", 32'(held), 32'h803C);
    send_byte(8'hF0, 1'b0);
    check("t4_state_break", 32'(dbg_state), 32'(BREAK));
    send_byte(8'h3C, 1'b1);
    check("t4_state_idle", 32'(dbg_state), 32'(IDLE));
    check("t4_held_kept", 32'(held), 32'h803C);
    send_byte(8'h1D, 1'b0); exp_q.push_back(4'd10);
    check("t4_held10", 32'(held), 32'h843C);
    pop_one("t4_pop");

    // 5: push and pop on the same cycle while full
    send_byte(8'h16, 1'b0); exp_q.push_back(4'd0);
    send_byte(8'h1E, 1'b0); exp_q.push_back(4'd1);
    send_byte(8'h26, 1'b0); exp_q.push_back(4'd2);
    send_byte(8'h25, 1'b0); exp_q.push_back(4'd3);
    idle(2);
    check("t5_count_full", 32'(fifo_count), 32'd4);
    @(negedge clk);
    bus.rx_valid = 1'b1; bus.rx_byte = 8'h3D;
    @(negedge clk);
    bus.rx_valid = 1'b0; bus.sel_ready = 1'b1;
    check("t5_head", 32'(bus.sel_quadrant), 32'(exp_q.pop_front()));
    exp_q.push_back(4'd6);
    @(negedge clk);
    bus.sel_ready = 1'b0;
    check("t5_count_same", 32'(fifo_count), 32'd4);
    check("t5_no_ovf", 32'(overflow), 32'd0);
    repeat (4) pop_one("t5_pop");

    // 6: typematic repeat of key 8
    send_byte(8'h46, 1'b0); exp_q.push_back(4'd8);
    send_byte(8'h46, 1'b0);
`ifndef TYPEMATIC_FILTER_EN
    exp_q.push_back(4'd8);
`endif
    send_byte(8'h46, 1'b0);
`ifndef TYPEMATIC_FILTER_EN
    exp_q.push_back(4'd8);
`endif
    idle(2);
    check("t6_count", 32'(fifo_count), 32'(exp_q.size()));
    check("t6_held8_set", 32'(held[8]), 32'd1);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h46, 1'b0);
    check("t6_held8_clr", 32'(held[8]), 32'd0);
    repeat (exp_q.size()) pop_one("t6_pop");
    check("t6_drained", 32'(fifo_count), 32'd0);

    // reset in the middle of a prefix sequence
    send_byte(8'hE0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    check("rst_mid_held",  32'(held), 32'd0);
    check("rst_mid_led",   32'(led), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h3C, 1'b0); exp_q.push_back(4'd15);
    pop_one("rst_mid_pop");
    check("end_valid", 32'(bus.sel_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
